fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU. It sits directly upstream of the decode stage:
- owns the program counter;
- requests instructions from instruction memory over a req/ack handshake;
- hands each instruction and its PC+4 to decode.

It honours a hold request from the hazard logic, accepts a redirect for jumps, jr and taken branches, and buffers one returning instruction so that no fetch is lost while decode is stalled.

---
 rtl/fetch_stage_if.sv | 9 +
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory req/ack bus between the fetch stage and instruction memory.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, output addr, input ack, input rdata);
    modport slave (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory request, one-entry skid buffer and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_pc_plus4,
    output logic                 if_valid
);
    typedef enum logic {FETCH, SKID} state_t;
    state_t      state, state_d;
    logic [31:0] pc, pc_d, pc_plus4, instr_d, pc4_d, skid_instr, skid_pc4, skid_instr_d, skid_pc4_d;
    logic        valid_d;
    assign pc_plus4  = pc + 32'd4;
    assign imem.req  = reset_n & (state == FETCH);
    assign imem.addr = pc;
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        instr_d      = if_instr;
        pc4_d        = if_pc_plus4;
        valid_d      = if_valid;
        skid_instr_d = skid_instr;
        skid_pc4_d   = skid_pc4;
        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = FETCH;
            instr_d = NOP;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (state == FETCH) begin
            if (!stall) begin
                instr_d = imem.ack ? imem.rdata : NOP;
                pc4_d   = pc_plus4;
                valid_d = imem.ack;
                pc_d    = imem.ack ? pc_plus4 : pc;
            end else if (imem.ack) begin
                // decode is held, so park the returning word instead of losing it
                skid_instr_d = imem.rdata;
                skid_pc4_d   = pc_plus4;
                pc_d         = pc_plus4;
                state_d      = SKID;
            end
        end else if (!stall) begin
            instr_d = skid_instr;
            pc4_d   = skid_pc4;
            valid_d = 1'b1;
            state_d = FETCH;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            if_instr    <= NOP;
            if_pc_plus4 <= '0;
            if_valid    <= 1'b0;
            skid_instr  <= NOP;
            skid_pc4    <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            if_instr    <= instr_d;
            if_pc_plus4 <= pc4_d;
            if_valid    <= valid_d;
            skid_instr  <= skid_instr_d;
            skid_pc4    <= skid_pc4_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus scoreboard of fetched words; memory word at address a is a.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] if_instr, if_pc_plus4;
    logic        if_valid;
    fetch_stage_if imem();
    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .imem(imem), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    vec_t        vecs[21];
    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    logic        p_stall, p_redir, p_req, p_ack, h_valid;
    logic [31:0] h_instr, h_pc4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_history();
        p_stall = 1'b0; p_redir = 1'b0; p_req = 1'b1; p_ack = 1'b0;
        sb.delete();
    endtask

    // Check outputs produced by the previous edge, then drive the next cycle's inputs.
    task automatic step(input vec_t v);
        chk("imem_req", {31'b0, imem.req}, {31'b0, v.exp_req});
        chk("imem_addr", imem.addr, v.exp_addr);
        if (p_redir) begin
            chk("redir_valid", {31'b0, if_valid}, 32'd0);
        end else if (p_stall) begin
            chk("hold_instr", if_instr, h_instr);
            chk("hold_pc4", if_pc_plus4, h_pc4);
            chk("hold_valid", {31'b0, if_valid}, {31'b0, h_valid});
        end else begin
            chk("valid", {31'b0, if_valid}, {31'b0, p_req ? p_ack : 1'b1});
            if (if_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("instr", if_instr, e.instr);
                    chk("pc_plus4", if_pc_plus4, e.pc4);
                end
            end
        end
        if (!if_valid) chk("bubble_nop", if_instr, NOP);
        h_instr = if_instr; h_pc4 = if_pc_plus4; h_valid = if_valid;
        stall = v.stall;
        redirect = v.redir;
        redirect_pc = v.rpc;
        imem.ack = v.ack & imem.req;
        imem.rdata = imem.addr;
        if (v.redir) sb.delete();
        else if (imem.ack) sb.push_back('{imem.addr, imem.addr + 32'd4});
        p_stall = v.stall; p_redir = v.redir; p_req = imem.req; p_ack = imem.ack;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_instr"}, if_instr, NOP);
        chk({tag, "_pc4"}, if_pc_plus4, 32'd0);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, "_req"}, {31'b0, imem.req}, 32'd0);
        chk({tag, "_addr"}, imem.addr, 32'd0);
    endtask

    initial begin
        imem.ack = 1'b0;
        imem.rdata = '0;
        //          stall redir rpc            ack req addr
        vecs[0]  = '{0, 0, 32'h0,          1, 1, 32'h0};
        vecs[1]  = '{0, 0, 32'h0,          1, 1, 32'h4};
        vecs[2]  = '{0, 0, 32'h0,          1, 1, 32'h8};
        vecs[3]  = '{0, 0, 32'h0,          1, 1, 32'hC};
        vecs[4]  = '{1, 0, 32'h0,          1, 1, 32'h10};
        vecs[5]  = '{1, 0, 32'h0,          1, 0, 32'h14};
        vecs[6]  = '{1, 0, 32'h0,          1, 0, 32'h14};
        vecs[7]  = '{0, 0, 32'h0,          1, 0, 32'h14};
        vecs[8]  = '{0, 0, 32'h0,          1, 1, 32'h14};
        vecs[9]  = '{0, 0, 32'h0,          1, 1, 32'h18};
        vecs[10] = '{0, 0, 32'h0,          0, 1, 32'h1C};
        vecs[11] = '{0, 0, 32'h0,          0, 1, 32'h1C};
        vecs[12] = '{0, 0, 32'h0,          1, 1, 32'h1C};
        vecs[13] = '{1, 0, 32'h0,          1, 1, 32'h20};
        vecs[14] = '{1, 1, 32'h103,        1, 0, 32'h24};
        vecs[15] = '{0, 0, 32'h0,          1, 1, 32'h100};
        vecs[16] = '{0, 1, 32'hFFFF_FFFC,  1, 1, 32'h104};
        vecs[17] = '{0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC};
        vecs[18] = '{0, 0, 32'h0,          1, 1, 32'h0};
        vecs[19] = '{1, 0, 32'h0,          1, 1, 32'h4};
        vecs[20] = '{1, 0, 32'h0,          0, 0, 32'h8};
        clear_history();
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 21; i++) step(vecs[i]);
        // asynchronous reset pulse while parked in SKID, between clock edges
        #2 reset_n = 1'b0;
        #1 chk_reset("async_reset");
        stall = 1'b0;
        redirect = 1'b0;
        imem.ack = 1'b0;
        clear_history();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        step('{0, 0, 32'h0, 1, 1, 32'h0});
        step('{0, 0, 32'h0, 1, 1, 32'h4});
        step('{0, 0, 32'h0, 0, 1, 32'h8});
        step('{0, 0, 32'h0, 1, 1, 32'h8});
        step('{0, 0, 32'h0, 0, 1, 32'hC});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
